// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round count, FSM states, round-constant helpers.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam logic [7:0]  RCON_INIT  = 8'h01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  // GF(2^8) multiply-by-x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // a^254 == a^-1 (and maps 0 to 0): product of a^2, a^4, ..., a^128.
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
  end

  assign s = inv
           ^ {inv[6:0], inv[7]}
           ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]}
           ^ 8'h63;

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key expansion: one round key per cycle into a register store, registered read port.
module aes_key_expand #(
  parameter int unsigned NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);
  import aes_pkg::*;

  localparam int unsigned KEY_W     = 128;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned NUM_SLOTS = NUM_ROUNDS + 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   round_q;
  logic [7:0]         rcon_q;
  logic               accept_c;
  logic               last_c;
  logic [KEY_W-1:0]   slot_q [NUM_SLOTS];
  logic [KEY_W-1:0]   prev_key;
  logic [KEY_W-1:0]   next_key;
  logic [31:0]        rot_word;
  logic [31:0]        sub_word;
  logic [31:0]        t_word;
  logic [31:0]        n0, n1, n2, n3;

  assign key_ready = (state_q != EXPAND);
  assign busy      = (state_q == EXPAND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    last_c   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (key_valid) begin
          accept_c = 1'b1;
          state_d  = EXPAND;
        end
      end
      EXPAND: begin
        if (round_q == IDX_W'(NUM_ROUNDS)) begin
          last_c  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next round key from the previous slot: RotWord, SubWord, Rcon, then the XOR chain.
  assign prev_key = slot_q[round_q - IDX_W'(1)];
  assign rot_word = {prev_key[23:0], prev_key[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sub
    aes_sbox u_sbox (
      .a (rot_word[8*b +: 8]),
      .s (sub_word[8*b +: 8])
    );
  end

  assign t_word   = sub_word ^ {rcon_q, 24'h0};
  assign n0       = prev_key[127:96] ^ t_word;
  assign n1       = prev_key[95:64]  ^ n0;
  assign n2       = prev_key[63:32]  ^ n1;
  assign n3       = prev_key[31:0]   ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_q    <= '0;
      rcon_q     <= RCON_INIT;
      keys_valid <= 1'b0;
    end else if (accept_c) begin
      round_q    <= IDX_W'(1);
      rcon_q     <= RCON_INIT;
      keys_valid <= 1'b0;
    end else if (state_q == EXPAND) begin
      round_q <= round_q + IDX_W'(1);
      rcon_q  <= xtime(rcon_q);
      if (last_c) keys_valid <= 1'b1;
    end
  end

  // Key store is plain registers; contents are qualified by keys_valid, so no reset.
  always_ff @(posedge clk) begin
    if (accept_c)                slot_q[0]       <= key_in;
    else if (state_q == EXPAND)  slot_q[round_q] <= next_key;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 rk_out <= '0;
    else if (32'(rk_idx) <= NUM_ROUNDS)      rk_out <= slot_q[rk_idx];
    else                                     rk_out <= '0;
  end

endmodule
